module_leds_rgb_sequencer: RTL and testbench

Bus-programmable controller that sequences the RGB LED driver by issuing its `color`/`we` write strobes. It holds a 4-step pattern table of {color, duration} and plays the table once or in a loop. A system alert input takes priority over the pattern, then the pattern resumes. The block sits between the CPU peripheral bus and the RGB LED driver; `color_o`/`we_o` connect directly to the driver's `color_i`/`we_i`.

---
 rtl/module_leds_rgb_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_module_leds_rgb_sequencer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_leds_rgb_sequencer.sv
// RGB LED pattern sequencer: plays a 4-step {color, duration} table once or looped
// and drives the LED driver's color/we strobes, with an alert override that freezes the pattern.
//
// state | meaning
// IDLE  | no pattern running; color_o holds last issued value
// PLAY  | current step counting down prescaler/tick counters
// ALERT | alert color shown; pattern state frozen, saved_play_q tells where to return
// LOAD  | one cycle: issue STEP[step].color and reload counters
module module_leds_rgb_sequencer #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TICK_MS = 10
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] rdata_o,
    input  logic        alert_i,
    output logic [2:0]  color_o,
    output logic        we_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int TICK_CYC = CLK_HZ / 1000 * TICK_MS;
    localparam int PW       = $clog2(TICK_CYC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_ALERT = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    logic [2:0] step_color_q [4];
    logic [7:0] step_dur_q [4];
    logic [2:0] alert_color_q;
    logic       loop_q;
    logic [1:0] last_q;

    state_t        state_q, state_d;
    logic          saved_play_q, saved_play_d;
    logic [1:0]    step_q, step_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tick_q, tick_d;
    logic [2:0]    color_q, color_d;
    logic          we_q, we_d;
    logic          done_q, done_d;

    logic wr_ctrl, wr_acol, wr_step;
    logic start_cmd, stop_cmd;
    logic last_step, step_fin, tick_end;
    logic [2:0] alert_color_nx;
    logic unused_data_bits;

    assign wr_ctrl   = we_i && (addr_i == 3'd0);
    assign wr_acol   = we_i && (addr_i == 3'd2);
    assign wr_step   = we_i && addr_i[2];
    assign stop_cmd  = wr_ctrl && data_i[2];
    assign start_cmd = wr_ctrl && data_i[0] && !data_i[2];
    assign alert_color_nx = wr_acol ? data_i[2:0] : alert_color_q;
    assign unused_data_bits = ^{data_i[31:16], data_i[7:6], data_i[3]};

    // Non-final steps end one cycle early so the following LOAD cycle completes D*TICK_CYC.
    assign last_step = (step_q >= last_q);
    assign step_fin  = last_step && !loop_q;
    assign tick_end  = (tick_q == 8'd0) &&
                       (step_fin ? (presc_q == '0) : (presc_q <= PW'(1)));

    function automatic logic [7:0] tick_init(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd0 : dur - 8'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 4; i++) begin
                step_color_q[i] <= 3'd0;
                step_dur_q[i]   <= 8'd1;
            end
            alert_color_q <= 3'd1;
            loop_q        <= 1'b0;
            last_q        <= 2'd0;
        end else begin
            if (wr_ctrl) begin
                loop_q <= data_i[1];
                last_q <= data_i[5:4];
            end
            if (wr_acol) begin
                alert_color_q <= data_i[2:0];
            end
            if (wr_step) begin
                step_color_q[addr_i[1:0]] <= data_i[2:0];
                step_dur_q[addr_i[1:0]]   <= data_i[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            saved_play_q <= 1'b0;
            step_q       <= 2'd0;
            presc_q      <= '0;
            tick_q       <= 8'd0;
            color_q      <= 3'd0;
            we_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_play_q <= saved_play_d;
            step_q       <= step_d;
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            color_q      <= color_d;
            we_q         <= we_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        saved_play_d = saved_play_q;
        step_d       = step_q;
        presc_d      = presc_q;
        tick_d       = tick_q;
        color_d      = color_q;
        we_d         = 1'b0;
        done_d       = done_q;

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    state_d = S_LOAD;
                    step_d  = 2'd0;
                    done_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (stop_cmd) begin
                    state_d = S_IDLE;
                    color_d = 3'd0;
                    we_d    = 1'b1;
                end else if (start_cmd) begin
                    step_d = 2'd0;
                    done_d = 1'b0;
                end else begin
                    state_d = S_PLAY;
                    color_d = step_color_q[step_q];
                    we_d    = 1'b1;
                    presc_d = PRESC_MAX;
                    tick_d  = tick_init(step_dur_q[step_q]);
                end
            end
            S_PLAY: begin
                if (stop_cmd) begin
                    state_d = S_IDLE;
                    color_d = 3'd0;
                    we_d    = 1'b1;
                end else if (start_cmd) begin
                    state_d = S_LOAD;
                    step_d  = 2'd0;
                    done_d  = 1'b0;
                end else if (tick_end) begin
                    if (step_fin) begin
                        state_d = S_IDLE;
                        color_d = 3'd0;
                        we_d    = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        step_d  = last_step ? 2'd0 : step_q + 2'd1;
                    end
                end else if (presc_q == '0) begin
                    presc_d = PRESC_MAX;
                    tick_d  = tick_q - 8'd1;
                end else begin
                    presc_d = presc_q - PW'(1);
                end
            end
            S_ALERT: begin
                if (stop_cmd) begin
                    saved_play_d = 1'b0;
                end else if (start_cmd) begin
                    saved_play_d = 1'b1;
                    step_d       = 2'd0;
                    done_d       = 1'b0;
                    presc_d      = PRESC_MAX;
                    tick_d       = tick_init(step_dur_q[0]);
                end
                if (!alert_i) begin
                    state_d = saved_play_d ? S_PLAY : S_IDLE;
                    color_d = saved_play_d ? step_color_q[step_d] : 3'd0;
                    we_d    = 1'b1;
                end else if (wr_acol) begin
                    color_d = data_i[2:0];
                    we_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Alert overrides whatever the pattern would have done; a pending LOAD is
        // folded into the freeze so the step restarts cleanly on release.
        if (alert_i && (state_q != S_ALERT)) begin
            saved_play_d = (state_d != S_IDLE);
            if (state_d == S_LOAD) begin
                presc_d = PRESC_MAX;
                tick_d  = tick_init(step_dur_q[step_d]);
            end
            state_d = S_ALERT;
            color_d = alert_color_nx;
            we_d    = 1'b1;
        end
    end

    assign color_o = color_q;
    assign we_o    = we_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == S_LOAD) || (state_q == S_PLAY) ||
                     ((state_q == S_ALERT) && saved_play_q);

    always_comb begin
        rdata_o = 32'd0;
        case (addr_i)
            3'd0: begin
                rdata_o[1]   = loop_q;
                rdata_o[5:4] = last_q;
            end
            3'd1: begin
                rdata_o[0]   = busy_o;
                rdata_o[1]   = done_q;
                rdata_o[5:4] = step_q;
                rdata_o[7:6] = state_q;
            end
            3'd2: rdata_o[2:0] = alert_color_q;
            3'd4, 3'd5, 3'd6, 3'd7: begin
                rdata_o[2:0]  = step_color_q[addr_i[1:0]];
                rdata_o[15:8] = step_dur_q[addr_i[1:0]];
            end
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_module_leds_rgb_sequencer.sv
// Bench for module_leds_rgb_sequencer: records every we_o pulse with its edge number and
// compares against event lists computed from step durations and alert windows.
module tb_module_leds_rgb_sequencer;

    localparam int TC = 10;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        we_i    = 1'b0;
    logic [2:0]  addr_i  = 3'd0;
    logic [31:0] data_i  = 32'd0;
    logic        alert_i = 1'b0;
    logic [31:0] rdata_o;
    logic [2:0]  color_o;
    logic        we_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ev_cyc[$];
    int ev_col[$];
    int ex_cyc[$];
    int ex_col[$];

    module_leds_rgb_sequencer #(.CLK_HZ(10000), .TICK_MS(1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .rdata_o(rdata_o), .alert_i(alert_i),
        .color_o(color_o), .we_o(we_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #50 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        if (we_o === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_col.push_back(int'(color_o));
        end
    end

    function automatic int deff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    task automatic wr(input int a, input int d, output int e);
        @(negedge clk_i);
        we_i = 1'b1; addr_i = 3'(a); data_i = 32'(d);
        @(negedge clk_i);
        we_i = 1'b0;
        e = cyc;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        addr_i = 3'(a);
        #1;
        d = rdata_o;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_i);
    endtask

    task automatic clear_ev();
        ev_cyc.delete(); ev_col.delete(); ex_cyc.delete(); ex_col.delete();
    endtask

    task automatic expect_ev(input int c, input int col);
        ex_cyc.push_back(c); ex_col.push_back(col);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int exp_rd[8] = '{0, 0, 1, 0, 256, 256, 256, 256};
        checks++;
        if ({color_o, we_o, busy_o, done_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got color=%0d we=%0d busy=%0d done=%0d want all 0", color_o, we_o, busy_o, done_o);
        end
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            checks++;
            if (d !== 32'(exp_rd[a])) begin
                errors++;
                $display("FAIL reset_reg[%0d] got 0x%0h want 0x%0h", a, d, exp_rd[a]);
            end
        end
    endtask

    task automatic test_one_shot();
        int col[4]; int dur[4]; int last; int k; int t;
        logic [31:0] d;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                last = 1;
                col = '{1, 2, 0, 0}; dur = '{2, 3, 1, 1};
            end else begin
                last = $urandom_range(0, 3);
                for (int s = 0; s < 4; s++) begin
                    col[s] = $urandom_range(1, 7);
                    dur[s] = $urandom_range(0, 4);
                end
            end
            for (int s = 0; s < 4; s++) wr(4 + s, (dur[s] << 8) | col[s], k);
            rd(4, d);
            checks++;
            if (d !== 32'((dur[0] << 8) | col[0])) begin
                errors++;
                $display("FAIL one_shot[%0d] step0 readback got 0x%0h want 0x%0h", it, d, (dur[0] << 8) | col[0]);
            end
            clear_ev();
            wr(0, (last << 4) | 1, k);
            t = k + 1;
            for (int s = 0; s <= last; s++) begin
                expect_ev(t, col[s]);
                t += TC * deff(dur[s]);
            end
            expect_ev(t, 0);
            wait_to(t + 3);
            checks++;
            if (ev_cyc.size() != ex_cyc.size()) begin
                errors++;
                $display("FAIL one_shot[%0d] pulse count got %0d want %0d", it, ev_cyc.size(), ex_cyc.size());
            end
            for (int i = 0; i < ex_cyc.size() && i < ev_cyc.size(); i++) begin
                checks++;
                if (ev_cyc[i] !== ex_cyc[i] || ev_col[i] !== ex_col[i]) begin
                    errors++;
                    $display("FAIL one_shot[%0d] pulse %0d got cyc %0d color %0d want cyc %0d color %0d", it, i, ev_cyc[i], ev_col[i], ex_cyc[i], ex_col[i]);
                end
            end
            checks++;
            if (done_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL one_shot[%0d] end flags got done=%0d busy=%0d want done=1 busy=0", it, done_o, busy_o);
            end
            rd(0, d);
            checks++;
            if (d !== 32'(last << 4)) begin
                errors++;
                $display("FAIL one_shot[%0d] ctrl readback got 0x%0h want 0x%0h", it, d, last << 4);
            end
        end
    endtask

    task automatic test_loop_stop();
        int col[3]; int dur[3]; int k; int s; int t; int p; int r; int idx;
        logic [31:0] d;
        for (int it = 0; it < 2; it++) begin
            p = 0;
            for (int i = 0; i < 3; i++) begin
                col[i] = $urandom_range(1, 7);
                dur[i] = $urandom_range(0, 3);
                p += TC * deff(dur[i]);
                wr(4 + i, (dur[i] << 8) | col[i], k);
            end
            clear_ev();
            wr(0, (2 << 4) | 2 | 1, k);
            r = $urandom_range(p + 5, 2 * p + 20);
            wait_to(k + r);
            wr(0, (2 << 4) | 2 | 4, s);
            t = k + 1; idx = 0;
            while (t < s) begin
                expect_ev(t, col[idx]);
                t += TC * deff(dur[idx]);
                idx = (idx + 1) % 3;
            end
            expect_ev(s, 0);
            wait_to(s + 5);
            checks++;
            if (ev_cyc.size() != ex_cyc.size()) begin
                errors++;
                $display("FAIL loop_stop[%0d] pulse count got %0d want %0d", it, ev_cyc.size(), ex_cyc.size());
            end
            for (int i = 0; i < ex_cyc.size() && i < ev_cyc.size(); i++) begin
                checks++;
                if (ev_cyc[i] !== ex_cyc[i] || ev_col[i] !== ex_col[i]) begin
                    errors++;
                    $display("FAIL loop_stop[%0d] pulse %0d got cyc %0d color %0d want cyc %0d color %0d", it, i, ev_cyc[i], ev_col[i], ex_cyc[i], ex_col[i]);
                end
            end
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL loop_stop[%0d] flags got done=%0d busy=%0d want 0 0", it, done_o, busy_o);
            end
            rd(0, d);
            checks++;
            if (d !== 32'h22) begin
                errors++;
                $display("FAIL loop_stop[%0d] ctrl readback got 0x%0h want 0x22", it, d);
            end
        end
        wr(0, 0, k);
    endtask

    task automatic test_alert_mid_step();
        int a; int len; int last; int c0; int c1; int ac; int d1; int k; int e; int t;
        logic [31:0] d;
        for (int it = 0; it < 2; it++) begin
            if (it == 0) begin
                a = 50; len = 100; last = 0;
            end else begin
                a = $urandom_range(2, 90); len = $urandom_range(3, 60); last = 1;
            end
            c0 = $urandom_range(1, 7); c1 = $urandom_range(1, 7);
            ac = $urandom_range(1, 7); d1 = $urandom_range(1, 3);
            wr(4, (10 << 8) | c0, k);
            wr(5, (d1 << 8) | c1, k);
            wr(2, ac, k);
            clear_ev();
            wr(0, (last << 4) | 1, k);
            e = k + 1;
            wait_to(e + a - 1);
            alert_i = 1'b1;
            wait_to(e + a + 1);
            rd(1, d);
            checks++;
            if (d[7:6] !== 2'd2 || d[0] !== 1'b1) begin
                errors++;
                $display("FAIL alert_mid[%0d] status got state=%0d busy=%0d want state=2 busy=1", it, d[7:6], d[0]);
            end
            wait_to(e + a + len - 1);
            alert_i = 1'b0;
            expect_ev(e, c0);
            expect_ev(e + a, ac);
            expect_ev(e + a + len, c0);
            t = e + TC * 10 + len;
            if (last == 0) begin
                expect_ev(t, 0);
            end else begin
                expect_ev(t, c1);
                t += TC * d1;
                expect_ev(t, 0);
            end
            wait_to(t + 3);
            checks++;
            if (ev_cyc.size() != ex_cyc.size()) begin
                errors++;
                $display("FAIL alert_mid[%0d] pulse count got %0d want %0d", it, ev_cyc.size(), ex_cyc.size());
            end
            for (int i = 0; i < ex_cyc.size() && i < ev_cyc.size(); i++) begin
                checks++;
                if (ev_cyc[i] !== ex_cyc[i] || ev_col[i] !== ex_col[i]) begin
                    errors++;
                    $display("FAIL alert_mid[%0d] pulse %0d got cyc %0d color %0d want cyc %0d color %0d", it, i, ev_cyc[i], ev_col[i], ex_cyc[i], ex_col[i]);
                end
            end
            checks++;
            if (done_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL alert_mid[%0d] end flags got done=%0d busy=%0d want done=1 busy=0", it, done_o, busy_o);
            end
        end
    endtask

    task automatic test_alert_idle();
        int k; int a; int w; int rel; int c2; int l1;
        logic [31:0] d;
        wr(2, 6, k);
        clear_ev();
        @(negedge clk_i);
        a = cyc + 1;
        alert_i = 1'b1;
        l1 = $urandom_range(3, 8);
        wait_to(a + l1);
        rd(1, d);
        checks++;
        if (busy_o !== 1'b0 || d[7:6] !== 2'd2) begin
            errors++;
            $display("FAIL alert_idle status got busy=%0d state=%0d want busy=0 state=2", busy_o, d[7:6]);
        end
        c2 = $urandom_range(1, 7);
        wr(2, c2, w);
        rd(2, d);
        checks++;
        if (d !== 32'(c2)) begin
            errors++;
            $display("FAIL alert_idle color readback got %0d want %0d", d, c2);
        end
        @(negedge clk_i);
        rel = cyc + 1;
        alert_i = 1'b0;
        wait_to(rel + 3);
        expect_ev(a, 6);
        expect_ev(w, c2);
        expect_ev(rel, 0);
        checks++;
        if (ev_cyc.size() != ex_cyc.size()) begin
            errors++;
            $display("FAIL alert_idle pulse count got %0d want %0d", ev_cyc.size(), ex_cyc.size());
        end
        for (int i = 0; i < ex_cyc.size() && i < ev_cyc.size(); i++) begin
            checks++;
            if (ev_cyc[i] !== ex_cyc[i] || ev_col[i] !== ex_col[i]) begin
                errors++;
                $display("FAIL alert_idle pulse %0d got cyc %0d color %0d want cyc %0d color %0d", i, ev_cyc[i], ev_col[i], ex_cyc[i], ex_col[i]);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL alert_idle busy after release got %0d want 0", busy_o);
        end
    endtask

    task automatic test_back_to_back();
        int k; int k1; int k2; int k3; int s;
        logic [31:0] d;
        wr(4, (2 << 8) | 3, k);
        wr(5, (2 << 8) | 5, k);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b done before restart got %0d want 1", done_o);
        end
        clear_ev();
        wr(0, (1 << 4) | 1, k1);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b start clears done got %0d want 0", done_o);
        end
        expect_ev(k1 + 1, 3);
        expect_ev(k1 + 21, 5);
        wait_to(k1 + 26);
        wr(0, (1 << 4) | 1, k2);
        expect_ev(k2 + 1, 3);
        wait_to(k2 + 6);
        wr(0, (1 << 4) | 5, s);
        expect_ev(s, 0);
        rd(1, d);
        checks++;
        if (d[7:0] !== 8'h00 && d[7:6] !== 2'd0) begin
            errors++;
            $display("FAIL b2b status after start_stop got 0x%0h want state=0 busy=0 done=0", d[7:0]);
        end
        checks++;
        if (d[7:6] !== 2'd0 || d[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL b2b state/busy/done after start_stop got 0x%0h want state 0 flags 0", d[7:0]);
        end
        wr(0, (1 << 4) | 1, k3);
        expect_ev(k3 + 1, 3);
        expect_ev(k3 + 21, 5);
        expect_ev(k3 + 41, 0);
        wait_to(k3 + 44);
        checks++;
        if (ev_cyc.size() != ex_cyc.size()) begin
            errors++;
            $display("FAIL b2b pulse count got %0d want %0d", ev_cyc.size(), ex_cyc.size());
        end
        for (int i = 0; i < ex_cyc.size() && i < ev_cyc.size(); i++) begin
            checks++;
            if (ev_cyc[i] !== ex_cyc[i] || ev_col[i] !== ex_col[i]) begin
                errors++;
                $display("FAIL b2b pulse %0d got cyc %0d color %0d want cyc %0d color %0d", i, ev_cyc[i], ev_col[i], ex_cyc[i], ex_col[i]);
            end
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b end flags got done=%0d busy=%0d want done=1 busy=0", done_o, busy_o);
        end
    endtask

    task automatic test_reset_mid_play();
        int k;
        logic [31:0] d;
        wr(4, (5 << 8) | 7, k);
        wr(2, 4, k);
        wr(0, (3 << 4) | 2 | 1, k);
        wait_to(k + 17);
        #10;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({color_o, we_o, busy_o, done_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_play outputs got color=%0d we=%0d busy=%0d done=%0d want all 0", color_o, we_o, busy_o, done_o);
        end
        clear_ev();
        repeat (3) @(negedge clk_i);
        checks++;
        if (ev_cyc.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_play pulses during reset got %0d want 0", ev_cyc.size());
        end
        rd(4, d);
        checks++;
        if (d !== 32'h100) begin
            errors++;
            $display("FAIL reset_mid_play step4 got 0x%0h want 0x100", d);
        end
        rd(2, d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_play alert_color got %0d want 1", d);
        end
        rd(0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_play ctrl got 0x%0h want 0", d);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (5) @(negedge clk_i);
        checks++;
        if (ev_cyc.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_play after release got pulses=%0d busy=%0d want 0 0", ev_cyc.size(), busy_o);
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_one_shot();
        test_loop_stop();
        test_alert_mid_step();
        test_alert_idle();
        test_back_to_back();
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
